dma_regs_nch: RTL and testbench
===============================

# dma_regs_nch

NCH-channel DMA control/status register file on the PCIe slave bus (BAR0 window). Holds the global DMA control word, the shared DMA length and one start address per receive channel, and returns per-channel current addresses. It also provides tear-free 64-bit global-counter and 32-bit current-address reads via read snapshots, and a masked, write-1-to-clear interrupt status that drives `sys_intr`. It replaces the fixed two-channel register decode in the board mid-level and sits between `pcie_tlp` (slave side) and the receiver/DMA engines.

## Interface
Parameters:
- `NCH`, 2: number of DMA channels, 1..8.
- `LEN_W`, 22: DMA length width in bytes; register holds bits `[LEN_W-1:2]`, LEN_W 18..32.

Ports:
- `sys_clk` in 1: single clock for the whole block.
- `sys_rst_n` in 1: reset, asynchronous and active-low.
- `slv_ce_i` in 1: access strobe, BAR0 already qualified, one cycle per access.
- `slv_we_i` in 1: 1 = write, 0 = read.
- `slv_adr_i` in 11 `[11:1]`: 16-bit word address.
- `slv_dat_i` in 16: write data, byte-swapped.
- `slv_sel_i` in 2: byte enables; `[1]` = low byte `slv_dat_i[15:8]`, `[0]` = high byte `slv_dat_i[7:0]`.
- `slv_dat_o` out 16: read data, byte-swapped.
- `global_counter` in 64: free-running timestamp.
- `dma_addr_cur` in NCH*30: channel c current address bits `[31:2]` at slice `[c*30+:30]`.
- `chan_done` in NCH: one-cycle event pulse per channel.
- `dma_enable` out 1: control bit 0.
- `dma_length` out LEN_W-2: length `[LEN_W-1:2]`.
- `dma_addr_start` out NCH*30: start address `[31:2]` per channel.
- `sys_intr` out 1: registered, level-sensitive interrupt.

## Operation
- **Byte order.** Each register value V is presented as `slv_dat_o = {V[7:0], V[15:8]}`. Writes: `sel[1]` loads `V[7:0] <= slv_dat_i[15:8]`; `sel[0]` loads `V[15:8] <= slv_dat_i[7:0]`.
- **Decode.** An access is decoded only when `slv_ce_i` is high and `slv_adr_i[11:7] == 0`. Otherwise a read returns 0 and a write is ignored.
- **Register map** (word address in `slv_adr_i[6:1]`):
  - 0x00 ID, read-only: V = {NCH[7:0], 8'h02}.
  - 0x02 counter `[15:0]`. A read also latches all 64 bits of `global_counter` into the snapshot and returns the live `[15:0]`.
  - 0x03 / 0x04 / 0x05: snapshot `[31:16]` / `[47:32]` / `[63:48]`.
  - 0x08 control: bit0 `dma_enable`; remaining bits read 0.
  - 0x09 intr status, bit c per channel: write 1 clears the bit; write 0 has no effect.
  - 0x0A intr mask, bit c per channel.
  - 0x0C length low; bits 1:0 read 0 and ignore writes.
  - 0x0D length high; bits above LEN_W-16 read 0.
  - Per channel c at 0x10+4c:
    - +0 start `[15:0]`; bits 1:0 read 0.
    - +1 start `[31:16]`.
    - +2 cur `[15:0]`, read-only. A read also latches cur `[31:16]` of the same channel into a single shared hold register.
    - +3 returns the hold register.
  - Channels at or above NCH, and any unlisted address: read 0, write ignored.
- **Read-only registers.** Writes to ID, counter, snapshot and cur words are ignored.
- **Interrupt status.** `chan_done[c]` sets status[c]. A set and a W1C on the same bit in the same cycle leaves the bit 1 (set wins).
- **Interrupt output.** `sys_intr` registered from `|(status & mask)`.
- **Read data when idle.** `slv_dat_o` holds its last value when `slv_ce_i` is low. A write cycle does not change `slv_dat_o`.

## Timing
- Read latency is 1 cycle: `slv_dat_o` is valid on the cycle after the `slv_ce_i` & ~`slv_we_i` cycle. No wait states; back-to-back accesses every cycle are supported.
- A write takes effect at the clock edge ending its `slv_ce_i` cycle. The corresponding output (`dma_enable`, `dma_length`, `dma_addr_start`) changes that edge.
- Snapshot latch and read-data register update on the same edge. A read of 0x03 issued the cycle after 0x02 returns the latched value.
- `chan_done` → status bit set: 1 edge. Status/mask change → `sys_intr`: 1 further edge.
- **Reset values** (async assert, synchronous-safe release):
  - `slv_dat_o` = 0.
  - `dma_enable` = 0.
  - `dma_length` = 0x1_0000 >> 2.
  - start[c] = (0x1000_0000 + c·0x10_0000) >> 2.
  - status = 0, mask = 0, snapshot = 0, hold = 0, `sys_intr` = 0.
- Reset asserted mid-access aborts it; no partial write survives.

## Test plan
- Reset defaults: release reset, read 0x0C/0x0D/0x10/0x11/0x14/0x15 → 0x0000 / 0x0100 / 0x0000 / 0x0010 / 0x0000 / 0x1010, all byte-swapped on the bus; `sys_intr` = 0.
- Byte enables: write 0x11 with dat 0xABCD, sel = 2'b10 → start[0][23:16] = 0xAB, `[31:24]` unchanged = 0x10; readback 0xAB10.
- Counter snapshot: `global_counter` = 0x1122_3344_5566_7788. Read 0x02, then advance the counter by 1000 and read 0x03..0x05 → 0x5566, 0x3344, 0x1122 (V values); 0x02 returns 0x7788.
- W1C collision: mask = 0x1, pulse `chan_done[0]` → `sys_intr` high 2 cycles later. Write 0x09 = 1 in the same cycle as another `chan_done[0]` → bit stays 1. Write 0x09 = 1 alone → `sys_intr` low 2 cycles later.
- Out-of-range: NCH=2. Write 0x18 = 0xFFFF and read it → 0; read `slv_adr_i[11:7]` = 1 → 0; no output changes.
- Cur hold: `dma_addr_cur`[1] = 0x0ABC_DEF0 >> 2. Read 0x16, change the input, read 0x17 → 0xDEF0 then 0x0ABC.

Source files
------------

// File: rtl/dma_regs_nch.sv
// DMA control/status register file for the PCIe slave bus (BAR0 window).
// Holds the global control word, the DMA length and per-channel start addresses.
// Returns per-channel current addresses.
// Offers tear-free counter/address reads through snapshot registers, and a
// masked write-1-to-clear interrupt status.
module dma_regs_nch #(
  parameter int NCH   = 2,
  parameter int LEN_W = 22
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                slv_ce_i,
  input  logic                slv_we_i,
  input  logic [11:1]         slv_adr_i,
  input  logic [15:0]         slv_dat_i,
  input  logic [1:0]          slv_sel_i,
  output logic [15:0]         slv_dat_o,
  input  logic [63:0]         global_counter,
  input  logic [NCH*30-1:0]   dma_addr_cur,
  input  logic [NCH-1:0]      chan_done,
  output logic                dma_enable,
  output logic [LEN_W-3:0]    dma_length,
  output logic [NCH*30-1:0]   dma_addr_start,
  output logic                sys_intr
);

  localparam logic [7:0]  NCH8    = 8'(NCH);
  localparam logic [15:0] ID_V    = {NCH8, 8'h02};
  localparam logic [31:0] LEN_RST = 32'h0001_0000;

  // Reset start address of channel c, in [31:2] form
  function automatic logic [29:0] start_rst(input int c);
    logic [31:0] a;
    a = 32'h1000_0000 + 32'(c) * 32'h0010_0000;
    return a[31:2];
  endfunction

  logic [5:0]  wa;
  logic        hit, wr, rd;
  logic [15:0] wdat_v;  // write data in register (un-swapped) order
  logic [15:0] wbe;     // per-bit write enable in register order

  assign wa     = slv_adr_i[6:1];
  assign hit    = slv_ce_i && (slv_adr_i[11:7] == 5'd0);
  assign wr     = hit && slv_we_i;
  assign rd     = hit && !slv_we_i;
  assign wdat_v = {slv_dat_i[7:0], slv_dat_i[15:8]};
  assign wbe    = {{8{slv_sel_i[0]}}, {8{slv_sel_i[1]}}};

  logic              enable_q, enable_n;
  logic [NCH-1:0]    status_q, mask_q, mask_n, clr;
  logic [LEN_W-1:2]  length_q, length_n;
  logic [29:0]       start_q [NCH];
  logic [29:0]       start_n [NCH];
  logic [63:16]      snap_q;
  logic [15:0]       hold_q, hold_n;
  logic [15:0]       dat_q, rd_v;
  logic              intr_q, snap_ld, hold_ld;

  // Address decode: read mux and next values of the writable registers
  always_comb begin
    rd_v     = '0;
    snap_ld  = 1'b0;
    hold_ld  = 1'b0;
    hold_n   = hold_q;
    enable_n = enable_q;
    mask_n   = mask_q;
    length_n = length_q;
    start_n  = start_q;
    clr      = '0;
    if (hit) begin
      case (wa)
        6'h00: rd_v = ID_V;
        6'h02: begin
          rd_v    = global_counter[15:0];
          snap_ld = rd;
        end
        6'h03: rd_v = snap_q[31:16];
        6'h04: rd_v = snap_q[47:32];
        6'h05: rd_v = snap_q[63:48];
        6'h08: begin
          rd_v = {15'd0, enable_q};
          if (wr && slv_sel_i[1]) enable_n = wdat_v[0];
        end
        6'h09: begin
          rd_v = 16'(status_q);
          if (wr) clr = wdat_v[NCH-1:0] & wbe[NCH-1:0];
        end
        6'h0A: begin
          rd_v = 16'(mask_q);
          if (wr) mask_n = (mask_q & ~wbe[NCH-1:0]) | (wdat_v[NCH-1:0] & wbe[NCH-1:0]);
        end
        6'h0C: begin
          rd_v = {length_q[15:2], 2'b00};
          if (wr) length_n[15:2] = (length_q[15:2] & ~wbe[15:2]) | (wdat_v[15:2] & wbe[15:2]);
        end
        6'h0D: begin
          rd_v = 16'(length_q[LEN_W-1:16]);
          if (wr) length_n[LEN_W-1:16] = (length_q[LEN_W-1:16] & ~wbe[LEN_W-17:0])
                                       | (wdat_v[LEN_W-17:0] & wbe[LEN_W-17:0]);
        end
        default: begin
          for (int c = 0; c < NCH; c++) begin
            if (wa == 6'(16 + 4*c)) begin
              rd_v = {start_q[c][13:0], 2'b00};
              if (wr) start_n[c][13:0] = (start_q[c][13:0] & ~wbe[15:2]) | (wdat_v[15:2] & wbe[15:2]);
            end
            if (wa == 6'(17 + 4*c)) begin
              rd_v = start_q[c][29:14];
              if (wr) start_n[c][29:14] = (start_q[c][29:14] & ~wbe) | (wdat_v & wbe);
            end
            if (wa == 6'(18 + 4*c)) begin
              rd_v    = {dma_addr_cur[c*30 +: 14], 2'b00};
              hold_ld = rd;
              hold_n  = dma_addr_cur[c*30+14 +: 16];
            end
            if (wa == 6'(19 + 4*c)) rd_v = hold_q;
          end
        end
      endcase
    end
  end

  // Register state, snapshots, read data and interrupt output
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      enable_q <= 1'b0;
      status_q <= '0;
      mask_q   <= '0;
      length_q <= LEN_RST[LEN_W-1:2];
      for (int c = 0; c < NCH; c++) start_q[c] <= start_rst(c);
      snap_q   <= '0;
      hold_q   <= '0;
      dat_q    <= '0;
      intr_q   <= 1'b0;
    end else begin
      enable_q <= enable_n;
      // a new completion event wins over a simultaneous clear
      status_q <= (status_q & ~clr) | chan_done;
      mask_q   <= mask_n;
      length_q <= length_n;
      start_q  <= start_n;
      if (snap_ld) snap_q <= global_counter[63:16];
      if (hold_ld) hold_q <= hold_n;
      if (slv_ce_i && !slv_we_i) dat_q <= {rd_v[7:0], rd_v[15:8]};
      intr_q   <= |(status_q & mask_q);
    end
  end

  genvar g;
  for (g = 0; g < NCH; g++) begin : g_start
    assign dma_addr_start[g*30 +: 30] = start_q[g];
  end

  assign slv_dat_o  = dat_q;
  assign dma_enable = enable_q;
  assign dma_length = length_q;
  assign sys_intr   = intr_q;

endmodule

// File: tb/tb_dma_regs_nch.sv
// Directed bench for dma_regs_nch (NCH=2, LEN_W=22) with hand-computed expectations.
module tb_dma_regs_nch;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ce = 1'b0, we = 1'b0;
  logic [11:1]  adr = '0;
  logic [15:0]  dat = '0;
  logic [1:0]   sel = 2'b00;
  logic [15:0]  dat_o;
  logic [63:0]  gcnt = '0;
  logic [59:0]  cur = '0;
  logic [1:0]   done = '0;
  logic         en;
  logic [19:0]  len;
  logic [59:0]  start;
  logic         intr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dma_regs_nch #(.NCH(2), .LEN_W(22)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .slv_ce_i(ce), .slv_we_i(we), .slv_adr_i(adr), .slv_dat_i(dat), .slv_sel_i(sel),
    .slv_dat_o(dat_o), .global_counter(gcnt), .dma_addr_cur(cur), .chan_done(done),
    .dma_enable(en), .dma_length(len), .dma_addr_start(start), .sys_intr(intr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [11:1] a, input logic [15:0] d, input logic [1:0] s);
    ce = 1'b1; we = 1'b1; adr = a; dat = d; sel = s;
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [11:1] a, input logic [15:0] exp_bus);
    ce = 1'b1; we = 1'b0; adr = a; sel = 2'b11;
    @(posedge clk); #1;
    ce = 1'b0;
    chk(tag, dat_o, exp_bus);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  initial begin
    #23 rst_n = 1'b1;
    @(posedge clk); #1;

    // reset defaults
    chk("rst_dat_o", dat_o, 16'h0000);
    chk("rst_enable", en, 1'b0);
    chk("rst_length", len, 20'h04000);
    chk("rst_start", start, {30'h0404_0000, 30'h0400_0000});
    chk("rst_intr", intr, 1'b0);
    rd("id", 11'h000, 16'h0202);
    rd("len_lo_rst", 11'h00C, 16'h0000);
    rd("len_hi_rst", 11'h00D, 16'h0100);
    rd("st0_lo_rst", 11'h010, 16'h0000);
    rd("st0_hi_rst", 11'h011, 16'h0010);
    rd("st1_lo_rst", 11'h014, 16'h0000);
    rd("st1_hi_rst", 11'h015, 16'h1010);

    // byte enables: only low byte of start[0][31:16]
    wr(11'h011, 16'hABCD, 2'b10);
    chk("dat_o_hold_on_write", dat_o, 16'h1010);
    chk("start0_byte", start[29:0], 30'h042A_C000);
    rd("st0_hi_byte", 11'h011, 16'hAB10);

    // control
    wr(11'h008, 16'h0100, 2'b11);
    chk("enable_set", en, 1'b1);
    rd("ctrl_rd", 11'h008, 16'h0100);

    // length, with low two bits and bits above LEN_W dropped
    wr(11'h00D, 16'h0300, 2'b11);
    chk("len_hi_wr", len, 20'h0C000);
    wr(11'h00C, 16'h3712, 2'b11);
    chk("len_lo_wr", len, 20'h0C48D);
    rd("len_lo_rd", 11'h00C, 16'h3412);
    wr(11'h00D, 16'hFFFF, 2'b11);
    chk("len_hi_clip", len, 20'hFC48D);
    rd("len_hi_rd", 11'h00D, 16'h3F00);

    // counter snapshot
    gcnt = 64'h1122_3344_5566_7788;
    rd("cnt_lo", 11'h002, 16'h8877);
    gcnt = gcnt + 64'd1000;
    rd("snap_31_16", 11'h003, 16'h6655);
    rd("snap_47_32", 11'h004, 16'h4433);
    rd("snap_63_48", 11'h005, 16'h2211);

    // interrupt: mask ch0, pulse done[0]
    wr(11'h00A, 16'h0100, 2'b11);
    done = 2'b01; tick; done = 2'b00;
    chk("intr_lag", intr, 1'b0);
    tick;
    chk("intr_set", intr, 1'b1);
    rd("status_set", 11'h009, 16'h0100);
    // W1C collides with a new event: set wins
    ce = 1'b1; we = 1'b1; adr = 11'h009; dat = 16'h0100; sel = 2'b11; done = 2'b01;
    tick;
    ce = 1'b0; we = 1'b0; done = 2'b00;
    rd("status_collide", 11'h009, 16'h0100);
    chk("intr_collide", intr, 1'b1);
    wr(11'h009, 16'h0100, 2'b11);
    chk("intr_clr_lag", intr, 1'b1);
    tick;
    chk("intr_clr", intr, 1'b0);
    // masked channel 1 event does not raise the interrupt
    done = 2'b10; tick; done = 2'b00;
    tick; tick;
    chk("intr_masked", intr, 1'b0);
    rd("status_ch1", 11'h009, 16'h0200);

    // out of range
    wr(11'h018, 16'hFFFF, 2'b11);
    rd("oor_chan", 11'h018, 16'h0000);
    rd("id_again", 11'h000, 16'h0202);
    rd("oor_hi_adr", {5'd1, 6'h00}, 16'h0000);
    wr({5'd1, 6'h08}, 16'h0000, 2'b11);
    chk("oor_enable", en, 1'b1);
    chk("oor_length", len, 20'hFC48D);
    chk("oor_start", start, {30'h0404_0000, 30'h042A_C000});

    // current-address hold
    cur[59:30] = 30'h02AF_37BC;
    rd("cur1_lo", 11'h016, 16'hF0DE);
    cur[59:30] = '0;
    rd("cur1_hold", 11'h017, 16'hBC0A);

    // reset in the middle of a write
    ce = 1'b1; we = 1'b1; adr = 11'h008; dat = 16'h0000; sel = 2'b11;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0;
    #2 rst_n = 1'b1;
    chk("midrst_enable", en, 1'b0);
    chk("midrst_length", len, 20'h04000);
    chk("midrst_dat_o", dat_o, 16'h0000);
    rd("midrst_hold", 11'h017, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
